// File: rtl/qam16_demap_rx.sv
// qam16_demap_rx: 16-QAM hard slicer + Gray demap, symbol FIFO,
// MSB-first valid/ready bit serializer and additive x^7+x^6+1 descrambler.
module qam16_demap_rx #(
  parameter int unsigned AMP        = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [6:0]  LFSR_RESET = 7'h7F
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        lfsr_seed,
  input  logic              lfsr_load,
  input  logic signed [7:0] I_in,
  input  logic signed [7:0] Q_in,
  input  logic              valid_in,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic              overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic signed [8:0] C_THR   = 9'(2 * AMP);
  localparam logic signed [8:0] C_THR_N = -C_THR;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  // Per-axis hard decision; 9-bit compare keeps -128/+127 from wrapping.
  function automatic logic [1:0] slice(input logic signed [7:0] x);
    logic signed [8:0] xs;
    xs = $signed({x[7], x});
    if (xs >= C_THR)            slice = 2'b10;
    else if (xs >= 9'sd0)       slice = 2'b11;
    else if (xs >= C_THR_N)     slice = 2'b01;
    else                        slice = 2'b00;
  endfunction

  logic [3:0]    w_sym;
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          w_empty, w_full, w_push, w_pop;
  logic [3:0]    w_head;

  state_t        r_state, w_state_n;
  logic [3:0]    r_shreg, w_shreg_n;
  logic [1:0]    r_cnt, w_cnt_n;
  logic [6:0]    r_lfsr, w_lfsr_n;
  logic          w_fb, w_accept, w_bit_n;
  logic          r_bit_out, r_bit_valid, r_overflow;

  assign w_sym   = {slice(I_in), slice(Q_in)};
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  // A pop in the same cycle frees the slot, so push-on-full still succeeds.
  assign w_push  = valid_in && (!w_full || w_pop);

  assign bit_out   = r_bit_out;
  assign bit_valid = r_bit_valid;
  assign overflow  = r_overflow;

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_sym;
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      if (valid_in && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Serializer next-state, FIFO pop, LFSR advance and next output bit.
  always_comb begin
    w_state_n = r_state;
    w_shreg_n = r_shreg;
    w_cnt_n   = r_cnt;
    w_pop     = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shreg_n = w_head;
          w_cnt_n   = 2'd3;
          w_state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_ready) begin
          w_accept = 1'b1;
          if (r_cnt == 2'd0) begin
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_shreg_n = w_head;
              w_cnt_n   = 2'd3;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_shreg_n = {r_shreg[2:0], 1'b0};
            w_cnt_n   = 2'(r_cnt - 2'd1);
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    w_fb = r_lfsr[6] ^ r_lfsr[5];
    if (lfsr_load)     w_lfsr_n = lfsr_seed;
    else if (w_accept) w_lfsr_n = {r_lfsr[5:0], w_fb};
    else               w_lfsr_n = r_lfsr;
    w_bit_n = (w_state_n == S_SHIFT) && (w_shreg_n[3] ^ w_lfsr_n[6] ^ w_lfsr_n[5]);
  end

  // Serializer / descrambler state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_lfsr      <= LFSR_RESET;
      r_bit_out   <= 1'b0;
      r_bit_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_shreg     <= w_shreg_n;
      r_cnt       <= w_cnt_n;
      r_lfsr      <= w_lfsr_n;
      r_bit_out   <= w_bit_n;
      r_bit_valid <= (w_state_n == S_SHIFT);
    end
  end

endmodule

// File: tb/tb_qam16_demap_rx.sv
// tb_qam16_demap_rx: directed self-checking bench for qam16_demap_rx.
module tb_qam16_demap_rx;

  logic              clk;
  logic              reset;
  logic [6:0]        lfsr_seed;
  logic              lfsr_load;
  logic signed [7:0] I_in;
  logic signed [7:0] Q_in;
  logic              valid_in;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready;
  logic              overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic rx_q[$];

  qam16_demap_rx dut (
    .clk       (clk),
    .reset     (reset),
    .lfsr_seed (lfsr_seed),
    .lfsr_load (lfsr_load),
    .I_in      (I_in),
    .Q_in      (Q_in),
    .valid_in  (valid_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every bit the sink accepts at the following rising edge.
  always @(negedge clk) begin
    if (!reset && bit_valid && bit_ready) rx_q.push_back(bit_out);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input int q);
    I_in     = 8'(i);
    Q_in     = 8'(q);
    valid_in = 1'b1;
  endtask

  task automatic send(input int i, input int q);
    drive(i, q);
    step();
    valid_in = 1'b0;
  endtask

  task automatic load_seed(input logic [6:0] s);
    lfsr_seed = s;
    lfsr_load = 1'b1;
    step();
    lfsr_load = 1'b0;
  endtask

  // Wait (bounded) for n accepted bits and pack them first-bit-in-MSB.
  task automatic grab(input int n, input string tag, output logic [31:0] v);
    int waited;
    waited = 0;
    v = '0;
    while (rx_q.size() < n && waited < 400) begin
      step();
      waited++;
    end
    if (rx_q.size() < n) check({tag, "_timeout"}, 32'(rx_q.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (rx_q.size() > 0) v = {v[30:0], rx_q.pop_front()};
      else                 v = {v[30:0], 1'b0};
    end
  endtask

  int          thr_i   [8] = '{64, 63, 0, -1, -64, -65, -128, 127};
  logic [31:0] thr_exp [8] = '{32'hB, 32'hF, 32'hF, 32'h7, 32'h7, 32'h3, 32'h3, 32'hB};

  initial begin
    logic [31:0] v;
    reset     = 1'b1;
    lfsr_seed = '0;
    lfsr_load = 1'b0;
    I_in      = '0;
    Q_in      = '0;
    valid_in  = 1'b0;
    bit_ready = 1'b0;
    repeat (3) step();
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_bit_out",   32'(bit_out),   32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    reset = 1'b0;
    step();

    // Raw mapping with seed 0, plus first-symbol latency.
    bit_ready = 1'b1;
    load_seed(7'h00);
    drive(96, -96);
    step();
    check("lat_e0", 32'(bit_valid), 32'd0);
    drive(-32, 32);
    step();
    check("lat_e1", 32'(bit_valid), 32'd1);
    valid_in = 1'b0;
    grab(8, "raw_map", v);
    check("raw_map", v, 32'h87);

    // Slicer thresholds on I with Q=0 (Q code 11).
    for (int k = 0; k < 8; k++) begin
      send(thr_i[k], 0);
      grab(4, "thr", v);
      check($sformatf("thr_I%0d", thr_i[k]), v, thr_exp[k]);
    end

    // Descrambler from seed 0x40; the second symbol exposes LFSR=0x08.
    repeat (2) step();
    load_seed(7'h40);
    send(-96, -96);
    grab(4, "descr", v);
    check("descr_sym", v, 32'h8);
    send(-96, -96);
    grab(4, "descr2", v);
    check("descr_lfsr08", v, 32'h3);

    // Backpressure: stall five cycles on the third bit of 1011.
    repeat (2) step();
    load_seed(7'h00);
    rx_q.delete();
    bit_ready = 1'b0;
    send(96, 32);
    step();
    check("bp_first", 32'({bit_valid, bit_out}), 32'b11);
    bit_ready = 1'b1;
    repeat (2) step();
    bit_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_hold%0d", k), 32'({bit_valid, bit_out}), 32'b11);
    end
    bit_ready = 1'b1;
    grab(4, "bp", v);
    check("bp_bits", v, 32'hB);

    // Overflow: P goes to the shift reg, s1..s4 fill FIFO, s5/s6 dropped.
    repeat (2) step();
    bit_ready = 1'b0;
    drive(-96, 96);  step();   // P  = 0010
    drive(96, 96);   step();   // s1 = 1010
    drive(32, -32);  step();   // s2 = 1101
    drive(-32, -96); step();   // s3 = 0100
    drive(-96, 32);  step();   // s4 = 0011
    check("ovf_pre", 32'(overflow), 32'd0);
    drive(32, 32);   step();   // s5 dropped
    check("ovf_after5", 32'(overflow), 32'd1);
    drive(-96, -96); step();   // s6 dropped
    valid_in  = 1'b0;
    bit_ready = 1'b1;
    grab(20, "ovf", v);
    check("ovf_bits", v, 32'h2AD43);
    repeat (10) step();
    check("ovf_no_extra", 32'(rx_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset while shifting with three symbols queued.
    bit_ready = 1'b0;
    drive(96, 96);   step();
    drive(32, 32);   step();
    drive(-32, -32); step();
    drive(-96, -96); step();
    valid_in = 1'b0;
    check("rst_pre_valid", 32'(bit_valid), 32'd1);
    reset = 1'b1;
    step();
    check("rst_mid_valid", 32'(bit_valid), 32'd0);
    check("rst_mid_ovf",   32'(overflow),  32'd0);
    reset = 1'b0;
    rx_q.delete();
    bit_ready = 1'b1;
    step();
    // LFSR 7F gives fb=0 for the first four bits, so data passes raw.
    send(96, -32);
    grab(4, "rst_new", v);
    check("rst_new_sym", v, 32'h9);
    repeat (10) step();
    check("rst_clean", 32'(rx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
